inv_shift_rows_stream: RTL and testbench
========================================

// Module: inv_shift_rows_stream
// PURPOSE
//   Byte-serial AES InvShiftRows stage for the decryption datapath. It is the inverse of the
//   128-bit combinational ShiftRows used on the encrypt side.
//   Accepts 16-byte states one byte per cycle, double-buffers them, and emits each state one
//   byte per cycle in inverse-shifted order. Sustains 1 byte/cycle with valid/ready on both sides.
//   State layout is row-major, MSB-first:
//     - byte k = bits [8k:8k+7] of the 128-bit state, with k = 4*r + c (row r, column c).
//     - Byte 0 is the first byte on the stream.
// PARAMETERS
//   BYTE_W     8   lane width; only 8 is supported, and the build fails via elaboration check otherwise.
//   NUM_BYTES  16  bytes per state; fixed at 16, with the same elaboration check.
// PORTS
//   clk          in   1       single clock, rising edge
//   rst          in   1       synchronous, active-high reset
//   s_valid      in   1       input byte valid
//   s_ready      out  1       input byte accepted when s_valid & s_ready
//   s_data       in   [0:7]   input byte, stream index order 0..15
//   s_last       in   1       marks byte 15 of a state
//   m_valid      out  1       output byte valid
//   m_ready      in   1       downstream accepts when m_valid & m_ready
//   m_data       out  [0:7]   output byte, stream index order 0..15
//   m_last       out  1       high with output byte 15
//   err_frame    out  1       sticky framing error; cleared only by rst
// BEHAVIOUR
//   Transform
//     - out[4r+c] = in[4r + ((c - r) mod 4)], i.e. row r is rotated right by r.
//     - Source index table: 0,1,2,3, 7,4,5,6, 10,11,8,9, 13,14,15,12.
//   Storage
//     - Two 16-byte banks with state wr_bank, wr_idx[3:0], rd_bank, rd_idx[3:0] and full[1:0].
//   Reset (rst=1 at an edge)
//     - wr_bank, rd_bank, wr_idx, rd_idx, full and err_frame all go to 0.
//     - Any partial or undrained state is dropped.
//     - While rst is high: s_ready=0, m_valid=0, m_last=0. m_data is don't-care while m_valid=0.
//   Input side
//     - s_ready = !rst & !full[wr_bank].
//     - On accept: bank[wr_bank][wr_idx] <= s_data.
//     - If wr_idx==15: full[wr_bank]<=1, wr_bank toggles, wr_idx<=0. Otherwise wr_idx increments.
//   Framing
//     - s_last accepted with wr_idx<15: err_frame<=1, the partial state is discarded (wr_idx<=0,
//       full unchanged), and that byte is not stored.
//     - wr_idx==15 accepted with s_last=0: err_frame<=1, but the state completes normally.
//   Output side
//     - m_valid = full[rd_bank].
//     - m_data = bank[rd_bank][SRC[rd_idx]].
//     - m_last = m_valid & (rd_idx==15).
//     - On handshake: rd_idx increments. At rd_idx==15: full[rd_bank]<=0, rd_bank toggles, rd_idx<=0.
//   Timing
//     - Latency: the first output byte is valid the cycle after the input byte 15 handshake.
//     - No combinational path from s_* to m_*. m_* derives only from registers.
//   Simultaneous events
//     - A fill-complete on one bank and a drain-complete on the other in the same cycle are both
//       applied; the two writes to full[] are to different bits.
//     - The same bank can never fill and drain at once, because a full bank is not writable.
//   Boundaries
//     - Both banks full: s_ready=0 until the drain of rd_bank completes.
//     - s_ready rises the cycle after that drain completes.
//     - Indices wrap 15 -> 0.
// STRUCTURE
//   aes_pkg
//     - localparam BYTE_W=8, NUM_BYTES=16.
//     - INV_SHIFT_SRC[0:15] table, plus function inv_shift_src(k) with the matching FWD table
//       for benches.
//   Sub-module state_bank16
//     - 16 x BYTE_W registers, 1 write port (we, widx, wdata) and 1 async read port (ridx, rdata).
//     - Instantiated twice. The top holds the pointers, full flags, framing check and output mux.
// TESTING
//   1. Single state, bytes 00..0F in, m_ready=1
//      -> out 00 01 02 03 07 04 05 06 0A 0B 08 09 0D 0E 0F 0C.
//      -> m_last only on 0C. m_valid rises 1 cycle after byte 0F is accepted.
//   2. Three back-to-back states with s_valid=1, m_ready=1
//      -> s_ready never drops, 48 output bytes contiguous, m_last every 16th byte.
//   3. m_ready=0 while 40 bytes are offered
//      -> exactly 32 accepted, then s_ready=0.
//      -> set m_ready=1: s_ready returns the cycle after the 16th output byte.
//   4. s_last on input byte 5
//      -> err_frame=1 and stays 1, no output.
//      -> the next 16-byte state is output correctly per the table.
//   5. rst asserted after output byte 7 of state 0
//      -> next cycle m_valid=0, s_ready=0. After release s_ready=1, err_frame=0.
//      -> a new state drains from byte 0.
//   6. 1000 random states with random s_valid/m_ready gaps
//      -> reference ShiftRows applied to each output state returns the input exactly.
//      -> err_frame stays 0.

Source files
------------

// File: rtl/inv_shift_rows_stream_pkg.sv
// Shared constants, types and index tables for the byte-serial AES InvShiftRows stage.
// Byte k of a state sits at row r = k/4, column c = k%4 (row-major, byte 0 first).
//   INV_SHIFT_SRC : output byte k is taken from input byte INV_SHIFT_SRC[k]
//                   (row r rotated right by r).
//   FWD_SHIFT_SRC : the matching encrypt-side ShiftRows table (row r rotated left by r).
//                   It is used to undo the stage when checking it.
package inv_shift_rows_stream_pkg;

  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = 16;

  typedef logic [3:0] idx_t;

  localparam idx_t LAST_IDX = 4'd15;

  localparam idx_t INV_SHIFT_SRC [0:15] = '{
    4'd0,  4'd1,  4'd2,  4'd3,
    4'd7,  4'd4,  4'd5,  4'd6,
    4'd10, 4'd11, 4'd8,  4'd9,
    4'd13, 4'd14, 4'd15, 4'd12
  };

  localparam idx_t FWD_SHIFT_SRC [0:15] = '{
    4'd0,  4'd1,  4'd2,  4'd3,
    4'd5,  4'd6,  4'd7,  4'd4,
    4'd10, 4'd11, 4'd8,  4'd9,
    4'd15, 4'd12, 4'd13, 4'd14
  };

  function automatic idx_t inv_shift_src(input idx_t k);
    return INV_SHIFT_SRC[k];
  endfunction

  function automatic idx_t fwd_shift_src(input idx_t k);
    return FWD_SHIFT_SRC[k];
  endfunction

endpackage

// File: rtl/inv_shift_rows_stream_if.sv
// Byte-stream bundle for inv_shift_rows_stream.
//   s_valid/s_ready/s_data/s_last : input byte stream, byte 15 of each state tagged by s_last
//   m_valid/m_ready/m_data/m_last : output byte stream, byte 15 of each state tagged by m_last
//   err_frame                     : sticky framing error reported by the stage
// Modports:
//   slave  : the stage itself (consumes s_*, produces m_* and err_frame)
//   master : the environment around the stage (produces s_*, consumes m_*)
interface inv_shift_rows_stream_if;
  import inv_shift_rows_stream_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [0:BYTE_W-1] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [0:BYTE_W-1] m_data;
  logic              m_last;
  logic              err_frame;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last, err_frame
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last, err_frame
  );

endinterface

// File: rtl/inv_shift_rows_stream_state_bank16.sv
// One 16-entry byte buffer holding a single AES state.
//   clk   : rising-edge clock
//   we    : write enable
//   widx  : write byte index
//   wdata : write byte
//   ridx  : read byte index (asynchronous read)
//   rdata : byte at ridx
module inv_shift_rows_stream_state_bank16
  import inv_shift_rows_stream_pkg::*;
#(
  parameter int W = BYTE_W
) (
  input  logic         clk,
  input  logic         we,
  input  idx_t         widx,
  input  logic [0:W-1] wdata,
  input  idx_t         ridx,
  output logic [0:W-1] rdata
);

  logic [0:W-1] mem [0:15];

  // NOTE: the storage array has no reset; the owner's full flag says when its contents
  // are meaningful, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/inv_shift_rows_stream.sv
// Byte-serial AES InvShiftRows stage with two state buffers.
// One bank fills from the input stream while the other drains in inverse-shifted order,
// sustaining one byte per cycle in both directions.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset; drops any partial or undrained state
//   bus : inv_shift_rows_stream_if.slave (s_* input stream, m_* output stream, err_frame)
// Output signals depend only on registers (and rst), never on s_*.
module inv_shift_rows_stream
  import inv_shift_rows_stream_pkg::*;
#(
  parameter int BYTE_W    = 8,
  parameter int NUM_BYTES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  inv_shift_rows_stream_if.slave bus
);

  if (BYTE_W != 8 || NUM_BYTES != 16) begin : gen_bad_params
    $error("inv_shift_rows_stream supports only BYTE_W=8 and NUM_BYTES=16");
  end

  logic              wrBank;
  logic              rdBank;
  idx_t              wrIdx;
  idx_t              rdIdx;
  logic [1:0]        full;
  logic              errFrame;

  logic              sAccept;
  logic              earlyLast;
  logic              storeByte;
  logic              mValid;
  logic              mAccept;
  idx_t              srcIdx;
  logic [0:BYTE_W-1] rdData [2];

  // A full bank is never writable, so filling and draining always touch different banks.
  assign bus.s_ready = !rst && !full[wrBank];
  assign sAccept     = bus.s_valid && bus.s_ready;
  // s_last before byte 15 aborts the partial state; that byte is not stored.
  assign earlyLast   = sAccept && bus.s_last && (wrIdx != LAST_IDX);
  assign storeByte   = sAccept && !earlyLast;

  assign mValid      = !rst && full[rdBank];
  assign mAccept     = mValid && bus.m_ready;
  assign srcIdx      = inv_shift_src(rdIdx);

  assign bus.m_valid   = mValid;
  assign bus.m_data    = rdData[rdBank];
  assign bus.m_last    = mValid && (rdIdx == LAST_IDX);
  assign bus.err_frame = errFrame;

  for (genvar b = 0; b < 2; b++) begin : gen_bank
    inv_shift_rows_stream_state_bank16 #(.W(BYTE_W)) u_bank (
      .clk   (clk),
      .we    (storeByte && (wrBank == 1'(b))),
      .widx  (wrIdx),
      .wdata (bus.s_data),
      .ridx  (srcIdx),
      .rdata (rdData[b])
    );
  end

  // NOTE: all state here is written with non-blocking assignments so every read in this
  // block sees the pre-edge value, e.g. full[wrBank] and full[rdBank] in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrBank   <= 1'b0;
      rdBank   <= 1'b0;
      wrIdx    <= '0;
      rdIdx    <= '0;
      full     <= '0;
      errFrame <= 1'b0;
    end else begin
      if (earlyLast) begin
        wrIdx    <= '0;
        errFrame <= 1'b1;
      end else if (storeByte) begin
        if (wrIdx == LAST_IDX) begin
          full[wrBank] <= 1'b1;
          wrBank       <= ~wrBank;
          wrIdx        <= '0;
          // A missing s_last is flagged, but the state is still complete and is kept.
          if (!bus.s_last) begin
            errFrame <= 1'b1;
          end
        end else begin
          wrIdx <= wrIdx + 4'd1;
        end
      end

      if (mAccept) begin
        if (rdIdx == LAST_IDX) begin
          full[rdBank] <= 1'b0;
          rdBank       <= ~rdBank;
          rdIdx        <= '0;
        end else begin
          rdIdx <= rdIdx + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Self-checking bench for inv_shift_rows_stream.
// A queue-based model turns every accepted 16-byte state into its expected output bytes
// (row r rotated right by r); a negedge monitor compares the DUT against it every cycle.
// Directed tests add literal expectations for data, latency, back-pressure and reset.
module tb_inv_shift_rows_stream;
  import inv_shift_rows_stream_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inv_shift_rows_stream_if bus();

  inv_shift_rows_stream dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   nChecks    = 0;
  int   nErrors    = 0;
  int   cycle      = 0;
  int   outCount   = 0;
  int   inAccepted = 0;
  int   readyDrops = 0;
  logic errExp     = 1'b0;
  bit   randReady  = 1'b0;

  logic [8:0]   expQ[$];      // {last, data} still owed by the DUT
  logic [7:0]   partial[$];   // bytes of the state being received
  logic [127:0] inStates[$];  // completed input states, byte k at [8k +: 8]
  logic [7:0]   outAcc[$];    // bytes of the output state being received
  logic [8:0]   outLog[$];    // every output byte seen, {last, data}
  int           outCycle[$];  // cycle index of every output byte

  int base;
  int acc0;
  int readyCycle;
  int wcnt;
  int lastCount;

  logic [7:0] t1Exp [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h07, 8'h04, 8'h05, 8'h06,
                             8'h0A, 8'h0B, 8'h08, 8'h09, 8'h0D, 8'h0E, 8'h0F, 8'h0C};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [8:0] outAt(input int i);
    return (i < outLog.size()) ? outLog[i] : 9'h1ff;
  endfunction

  // ---------------- model + compare (every cycle, away from the active edge) -------------
  always @(negedge clk) begin : monitor
    int           nStored;
    logic [8:0]   e;
    logic [127:0] rec;
    logic [127:0] inSt;
    cycle++;
    if (rst) begin
      check("rst_s_ready", bus.s_ready, 0);
      check("rst_m_valid", bus.m_valid, 0);
      check("rst_m_last",  bus.m_last,  0);
      expQ.delete();
      partial.delete();
      inStates.delete();
      outAcc.delete();
      errExp = 1'b0;
    end else begin
      nStored = (expQ.size() + 15) / 16;
      check("s_ready",   bus.s_ready,   nStored < 2);
      check("m_valid",   bus.m_valid,   expQ.size() != 0);
      check("err_frame", bus.err_frame, errExp);
      if (bus.s_valid && !bus.s_ready) readyDrops++;

      if (bus.m_valid && bus.m_ready) begin
        outCount++;
        outLog.push_back({bus.m_last, bus.m_data});
        outCycle.push_back(cycle);
        check("out_expected", expQ.size() != 0, 1);
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          check("m_data", bus.m_data, e[7:0]);
          check("m_last", bus.m_last, e[8]);
        end
        outAcc.push_back(bus.m_data);
        if (outAcc.size() == 16) begin
          for (int k = 0; k < 16; k++) rec[8*k +: 8] = outAcc[fwd_shift_src(4'(k))];
          check("roundtrip_have_input", inStates.size() != 0, 1);
          if (inStates.size() != 0) check("fwd_shift_roundtrip", rec, inStates.pop_front());
          outAcc.delete();
        end
      end

      if (bus.s_valid && bus.s_ready) begin
        inAccepted++;
        if (bus.s_last && partial.size() < 15) begin
          errExp = 1'b1;
          partial.delete();
        end else begin
          partial.push_back(bus.s_data);
          if (partial.size() == 16) begin
            if (!bus.s_last) errExp = 1'b1;
            for (int k = 0; k < 16; k++) begin
              int r;
              int c;
              r = k / 4;
              c = k % 4;
              expQ.push_back({k == 15, partial[4*r + ((c - r + 4) % 4)]});
              inSt[8*k +: 8] = partial[k];
            end
            inStates.push_back(inSt);
            partial.delete();
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (randReady) begin
      #1;
      bus.m_ready = ($urandom_range(3, 0) != 0);
    end
  end

  // ---------------- driver helpers (enter and leave 1 time unit after a rising edge) -----
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input int gapMax);
    int w;
    repeat ($urandom_range(gapMax, 0)) begin
      bus.s_valid = 1'b0;
      step();
    end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    w = 0;
    forever begin
      @(negedge clk);
      if (bus.s_ready || w >= 2000) break;
      w++;
    end
    check("s_accept_timeout", w < 2000, 1);
    step();
  endtask

  task automatic wait_drain(input string tag);
    int w;
    w = 0;
    bus.s_valid = 1'b0;
    while ((expQ.size() != 0 || bus.m_valid) && w < 5000) begin
      @(negedge clk);
      #1;
      w++;
    end
    check({tag, "_drained"}, expQ.size() == 0, 1);
    step();
  endtask

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("reset_s_ready",   bus.s_ready,   1);
    check("reset_m_valid",   bus.m_valid,   0);
    check("reset_err_frame", bus.err_frame, 0);
    step();

    // Test 1: single state 00..0F, latency and literal output order.
    bus.m_ready = 1'b1;
    base = outCount;
    for (int i = 0; i < 16; i++) send_byte(8'(i), i == 15, 0);
    @(negedge clk);
    check("t1_latency_m_valid", bus.m_valid, 1);
    step();
    wait_drain("t1");
    for (int k = 0; k < 16; k++) begin
      check("t1_data", outAt(base + k), {k == 15, t1Exp[k]});
    end

    // Test 2: three back-to-back states.
    readyDrops = 0;
    base = outCount;
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 16; k++) send_byte(8'(8'h20 + 16*s + k), k == 15, 0);
    wait_drain("t2");
    check("t2_ready_drops", readyDrops, 0);
    check("t2_out_count", outCount - base, 48);
    if (outCount - base >= 48) check("t2_contiguous", outCycle[base+47] - outCycle[base], 47);
    lastCount = 0;
    for (int i = base; i < outLog.size(); i++) if (outLog[i][8]) lastCount++;
    check("t2_last_count", lastCount, 3);

    // Test 3: back-pressure fills both banks.
    bus.m_ready = 1'b0;
    acc0 = inAccepted;
    for (int i = 0; i < 32; i++) send_byte(8'(8'h60 + i), (i % 16) == 15, 0);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h80;
    bus.s_last  = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("t3_stalled_s_ready", bus.s_ready, 0);
    end
    step();
    check("t3_accepted_32", inAccepted - acc0, 32);
    base = outCount;
    bus.m_ready = 1'b1;
    wcnt = 0;
    forever begin
      @(negedge clk);
      #1;
      if (bus.s_ready || wcnt >= 200) break;
      wcnt++;
    end
    readyCycle = cycle;
    check("t3_ready_returned", bus.s_ready, 1);
    if (outCount - base >= 16) check("t3_ready_after_16th", readyCycle - outCycle[base+15], 1);
    else check("t3_16_outputs", outCount - base, 16);
    step();
    for (int i = 33; i < 48; i++) send_byte(8'(8'h60 + i), (i % 16) == 15, 0);
    wait_drain("t3");
    check("t3_accepted_total", inAccepted - acc0, 48);

    // Test 4: early s_last aborts a partial state; the next state is still correct.
    base = outCount;
    for (int i = 0; i < 6; i++) send_byte(8'(8'h30 + i), i == 5, 0);
    bus.s_valid = 1'b0;
    repeat (20) step();
    check("t4_no_output", outCount - base, 0);
    check("t4_err_frame", bus.err_frame, 1);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i), i == 15, 0);
    wait_drain("t4");
    check("t4_byte4",  outAt(base + 4),  {1'b0, 8'h47});
    check("t4_byte15", outAt(base + 15), {1'b1, 8'h4C});
    check("t4_err_sticky", bus.err_frame, 1);

    // Test 5: reset in the middle of draining a state.
    for (int i = 0; i < 16; i++) send_byte(8'(8'h90 + i), i == 15, 0);
    bus.s_valid = 1'b0;
    base = outCount - (16 - expQ.size());
    wcnt = 0;
    forever begin
      @(negedge clk);
      #1;
      if (outCount >= base + 8 || wcnt >= 200) break;
      wcnt++;
    end
    check("t5_reached_byte7", outCount >= base + 8, 1);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_m_valid", bus.m_valid, 0);
    check("t5_rst_s_ready", bus.s_ready, 0);
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t5_post_s_ready",   bus.s_ready,   1);
    check("t5_post_err_frame", bus.err_frame, 0);
    check("t5_post_m_valid",   bus.m_valid,   0);
    step();
    base = outCount;
    for (int i = 0; i < 16; i++) send_byte(8'(8'hC0 + i), i == 15, 0);
    wait_drain("t5");
    check("t5_new_byte0", outAt(base),     {1'b0, 8'hC0});
    check("t5_new_byte4", outAt(base + 4), {1'b0, 8'hC7});

    // Test 6: random states with gaps on both sides.
    randReady = 1'b1;
    base = outCount;
    for (int s = 0; s < 1000; s++)
      for (int k = 0; k < 16; k++) send_byte(8'($urandom), k == 15, 1);
    wait_drain("t6");
    randReady = 1'b0;
    bus.m_ready = 1'b1;
    check("t6_out_count", outCount - base, 16000);
    check("t6_err_frame", bus.err_frame, 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
